f2h_burst_writer: RTL

//  Avalon-MM burst write initiator driving an HPS f2h_sdram write-only port (address/burstcount/writedata/

---
 rtl/f2h_pkg.sv | 14 +
 rtl/f2h_write_fifo.sv | 59 +++++
 rtl/f2h_burst_writer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/f2h_pkg.sv
// Shared widths, defaults and FSM state encoding for the f2h_sdram burst writer.
package f2h_pkg;
    localparam int AVM_BURST_W    = 8;
    localparam int ADDR_WIDTH_DEF = 29;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int WORD_CNT_W     = 24;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2,
        DONE      = 2'd3
    } state_e;
endpackage

// File: rtl/f2h_write_fifo.sv
// Show-ahead FIFO: pop_data always presents the head word; push/pop may occur in the same cycle.
module f2h_write_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; emptiness is defined by the pointers/count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/f2h_burst_writer.sv
// Avalon-MM burst write initiator: buffers a 64-bit stream and writes it to SDRAM in whole,
// bubble-free bursts of up to BURST_LEN beats.
module f2h_burst_writer
    import f2h_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_address,
    input  logic [23:0]               word_count,
    output logic                      busy,
    output logic                      done,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ADDR_WIDTH-1:0]     avm_address,
    output logic [7:0]                avm_burstcount,
    input  logic                      avm_waitrequest,
    output logic [DATA_WIDTH-1:0]     avm_writedata,
    output logic [DATA_WIDTH/8-1:0]   avm_byteenable,
    output logic                      avm_write,
    output logic [1:0]                dbg_state
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    next_addr_q, next_addr_d;
    logic [WORD_CNT_W-1:0]    words_left_q, words_left_d;
    logic [WORD_CNT_W-1:0]    word_count_q, word_count_d;
    logic [WORD_CNT_W-1:0]    words_acc_q, words_acc_d;
    logic [AVM_BURST_W-1:0]   beats_left_q, beats_left_d;
    logic [ADDR_WIDTH-1:0]    avm_address_q, avm_address_d;
    logic [AVM_BURST_W-1:0]   avm_burstcount_q, avm_burstcount_d;
    logic                     avm_write_q, avm_write_d;

    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full, fifo_empty;
    logic                     push, beat_fire;
    logic [AVM_BURST_W-1:0]   blen;

    // Handshakes: a stream word transfers on a rising edge with in_valid && in_ready; an Avalon
    // beat transfers on a rising edge with avm_write && !avm_waitrequest. Neither side may
    // withdraw a request based on the other's response within the same cycle.
    assign busy           = (state_q == WAIT_DATA) || (state_q == BURST);
    assign done           = (state_q == DONE);
    assign in_ready       = busy && !fifo_full && (words_acc_q < word_count_q);
    assign push           = in_valid && in_ready;
    assign beat_fire      = avm_write_q && !avm_waitrequest;
    assign blen           = (words_left_q >= WORD_CNT_W'(BURST_LEN)) ? AVM_BURST_W'(BURST_LEN)
                                                                     : words_left_q[AVM_BURST_W-1:0];
    assign avm_address    = avm_address_q;
    assign avm_burstcount = avm_burstcount_q;
    assign avm_write      = avm_write_q;
    assign avm_byteenable = '1;
    assign dbg_state      = state_q;

    f2h_write_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (push),
        .push_data (in_data),
        .pop       (beat_fire),
        .pop_data  (avm_writedata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d          = state_q;
        next_addr_d      = next_addr_q;
        words_left_d     = words_left_q;
        word_count_d     = word_count_q;
        words_acc_d      = push ? words_acc_q + WORD_CNT_W'(1) : words_acc_q;
        beats_left_d     = beats_left_q;
        avm_address_d    = avm_address_q;
        avm_burstcount_d = avm_burstcount_q;
        avm_write_d      = avm_write_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    next_addr_d  = base_address;
                    word_count_d = word_count;
                    words_left_d = word_count;
                    words_acc_d  = '0;
                    state_d      = (word_count == '0) ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // Whole burst must be buffered so avm_write never drops mid-burst.
                if (32'(fifo_count) >= 32'(blen)) begin
                    avm_address_d    = next_addr_q;
                    avm_burstcount_d = blen;
                    beats_left_d     = blen;
                    avm_write_d      = 1'b1;
                    state_d          = BURST;
                end
            end
            BURST: begin
                if (beat_fire) begin
                    beats_left_d = beats_left_q - AVM_BURST_W'(1);
                    if (beats_left_q == AVM_BURST_W'(1)) begin
                        avm_write_d  = 1'b0;
                        next_addr_d  = next_addr_q + ADDR_WIDTH'(avm_burstcount_q);
                        words_left_d = words_left_q - WORD_CNT_W'(avm_burstcount_q);
                        state_d      = (words_left_q == WORD_CNT_W'(avm_burstcount_q)) ? DONE : WAIT_DATA;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q          <= IDLE;
            next_addr_q      <= '0;
            words_left_q     <= '0;
            word_count_q     <= '0;
            words_acc_q      <= '0;
            beats_left_q     <= '0;
            avm_address_q    <= '0;
            avm_burstcount_q <= '0;
            avm_write_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            next_addr_q      <= next_addr_d;
            words_left_q     <= words_left_d;
            word_count_q     <= word_count_d;
            words_acc_q      <= words_acc_d;
            beats_left_q     <= beats_left_d;
            avm_address_q    <= avm_address_d;
            avm_burstcount_q <= avm_burstcount_d;
            avm_write_q      <= avm_write_d;
        end
    end
endmodule
